// File: rtl/taitosj_rom_loader.sv
// taitosj_rom_loader: routes the hps_io index-0 download into four region ROM write strobes through a small FIFO.
//   clk_sys, reset (sync, active-high)
//   ioctl_download/index/wr/addr/dout in, ioctl_wait out: hps_io download port and backpressure
//   core_busy in: core stalls ROM writes; rom_addr/rom_data/rom_we out: region-relative one-hot write
//   pcb out: last index-1 byte; load_done out: one-cycle end-of-load pulse
//   overflow out: sticky FIFO-full discard; dropped_cnt out: saturating count of out-of-range bytes
//   TAITOSJ_LOADER_CKSUM_EN adds rom_cksum out: 16-bit sum of bytes presented on rom_we
module taitosj_rom_loader #(
  parameter int          FIFO_AW  = 3,
  parameter logic [24:0] MAIN_END = 25'h0C000,
  parameter logic [24:0] SND_END  = 25'h0E000,
  parameter logic [24:0] GFX_END  = 25'h16000,
  parameter logic [24:0] PROM_END = 25'h16100
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        core_busy,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [3:0]  rom_we,
  output logic [7:0]  pcb,
  output logic        load_done,
  output logic        overflow,
`ifdef TAITOSJ_LOADER_CKSUM_EN
  output logic [15:0] rom_cksum,
`endif
  output logic [15:0] dropped_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [25:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] cnt, cnt_n;
  logic load_entry, wr0, in_rom, full, push, ovf, drop, pop;
  logic [1:0] region;
  logic [24:0] base;
  logic [15:0] rel;
  always_comb begin
    state_n = state == IDLE  ? (ioctl_download && ioctl_index == 8'd0 ? LOAD : IDLE)
            : state == LOAD  ? (ioctl_download ? LOAD : FLUSH)
            : state == FLUSH ? (cnt == '0 && rom_we == 4'b0 ? DONE : FLUSH)
            : IDLE;
    load_entry = state == IDLE && state_n == LOAD;
    wr0 = state == LOAD && ioctl_wr && ioctl_index == 8'd0;
    in_rom = ioctl_addr < PROM_END;
    full = cnt == (FIFO_AW+1)'(DEPTH);
    push = wr0 && in_rom && !full;
    ovf = wr0 && in_rom && full;
    drop = wr0 && !in_rom;
    pop = cnt != '0 && !core_busy;
    cnt_n = cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    region = ioctl_addr < MAIN_END ? 2'd0 : ioctl_addr < SND_END ? 2'd1 : ioctl_addr < GFX_END ? 2'd2 : 2'd3;
    base = region == 2'd0 ? 25'd0 : region == 2'd1 ? MAIN_END : region == 2'd2 ? SND_END : GFX_END;
    rel = 16'(ioctl_addr - base);
  end
  always_ff @(posedge clk_sys)
    if (push) mem[wp] <= {region, rel, ioctl_dout};
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ioctl_wait <= 1'b0;
      rom_we <= 4'b0;
      rom_addr <= 16'd0;
      rom_data <= 8'd0;
      pcb <= 8'd0;
      overflow <= 1'b0;
      dropped_cnt <= 16'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (pop) {rom_addr, rom_data} <= mem[rp][23:0];
      rom_we <= pop ? 4'b0001 << mem[rp][25:24] : 4'b0;
      // wait tracks the post-edge occupancy so an in-flight byte always finds room
      ioctl_wait <= state_n != IDLE && cnt_n >= (FIFO_AW+1)'(DEPTH-2);
      if (ioctl_wr && ioctl_index == 8'd1) pcb <= ioctl_dout;
      overflow <= load_entry ? 1'b0 : overflow | ovf;
      dropped_cnt <= load_entry ? 16'd0 : drop && dropped_cnt != 16'hFFFF ? dropped_cnt + 16'd1 : dropped_cnt;
    end
  end
  assign load_done = state == DONE;
`ifdef TAITOSJ_LOADER_CKSUM_EN
  always_ff @(posedge clk_sys)
    if (reset || load_entry) rom_cksum <= 16'd0;
    else if (pop) rom_cksum <= rom_cksum + 16'(mem[rp][7:0]);
`endif
endmodule

// File: tb/tb_taitosj_rom_loader.sv
// tb_taitosj_rom_loader: directed self-checking bench for taitosj_rom_loader.
module tb_taitosj_rom_loader;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic        core_busy = 1'b0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;
  logic [7:0]  pcb;
  logic        load_done;
  logic        overflow;
  logic [15:0] dropped_cnt;
`ifdef TAITOSJ_LOADER_CKSUM_EN
  logic [15:0] rom_cksum;
`endif
  int checks = 0;
  int failures = 0;
  logic [27:0] wlog[$];

  taitosj_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .core_busy(core_busy), .rom_addr(rom_addr), .rom_data(rom_data), .rom_we(rom_we), .pcb(pcb),
    .load_done(load_done), .overflow(overflow),
`ifdef TAITOSJ_LOADER_CKSUM_EN
    .rom_cksum(rom_cksum),
`endif
    .dropped_cnt(dropped_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys)
    if (rom_we != 4'b0) wlog.push_back({rom_we, rom_addr, rom_data});

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_index = idx;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    ioctl_index = 8'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] entry(input int i);
    return i < wlog.size() ? 32'(wlog[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int n;
    logic [15:0] sum;
    tick(3);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_we", rom_we, 0);
    chk("rst_addr_data", {rom_addr, rom_data}, 0);
    chk("rst_done_ovf", {load_done, overflow}, 0);
    chk("rst_drop_pcb", {dropped_cnt, pcb}, 0);
    reset = 1'b0;
    ioctl_download = 1'b1;
    tick();
    wr_byte(0, 25'd0, 8'hA0);
    chk("lat_n1", rom_we, 0);
    wr_byte(0, 25'd1, 8'hA1);
    chk("lat_n2_we", rom_we, 4'b0001);
    chk("lat_n2_ad", {rom_addr, rom_data}, {16'h0000, 8'hA0});
    wr_byte(0, 25'd2, 8'hA2);
    wr_byte(0, 25'd3, 8'hA3);
    tick(4);
    chk("t1_cnt", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_e%0d", i), entry(i), {4'b0001, 16'(i), 8'hA0 + 8'(i)});
    wr_byte(0, 25'h0C005, 8'h55);
    wr_byte(0, 25'h16010, 8'h66);
    tick(4);
    chk("t2_snd", entry(4), {4'b0010, 16'h0005, 8'h55});
    chk("t2_prom", entry(5), {4'b1000, 16'h0010, 8'h66});
    core_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_byte(0, 25'h100 + 25'(i), 8'h10 + 8'(i));
      if (i == 4) chk("t3_wait5", ioctl_wait, 0);
    end
    chk("t3_wait6", ioctl_wait, 1);
    chk("t3_ovf", overflow, 0);
    chk("t3_held", wlog.size(), 6);
    core_busy = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin tick(); n++; end
    chk("t3_release", ioctl_wait, 0);
    wr_byte(0, 25'h106, 8'h16);
    wr_byte(0, 25'h107, 8'h17);
    tick(12);
    chk("t3_cnt", wlog.size(), 14);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_e%0d", i), entry(6 + i), {4'b0001, 16'h0100 + 16'(i), 8'h10 + 8'(i)});
    core_busy = 1'b1;
    for (int i = 0; i < 10; i++) wr_byte(0, 25'h200 + 25'(i), 8'h30 + 8'(i));
    chk("t4_ovf", overflow, 1);
    core_busy = 1'b0;
    tick(12);
    chk("t4_cnt", wlog.size(), 22);
    chk("t4_first", entry(14), {4'b0001, 16'h0200, 8'h30});
    chk("t4_last", entry(21), {4'b0001, 16'h0207, 8'h37});
    for (int i = 0; i < 3; i++) wr_byte(0, 25'h20000, 8'hEE);
    wr_byte(0, 25'h16100, 8'hEF);
    wr_byte(0, 25'h160FF, 8'h99);
    tick(4);
    chk("t5_drop", dropped_cnt, 4);
    chk("t5_cnt", wlog.size(), 23);
    chk("t5_edge", entry(22), {4'b1000, 16'h00FF, 8'h99});
`ifdef TAITOSJ_LOADER_CKSUM_EN
    sum = 16'd0;
    foreach (wlog[i]) sum += 16'(wlog[i][7:0]);
    chk("cksum", rom_cksum, sum);
`endif
    ioctl_download = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (load_done) n++;
    end
    chk("t5_done_pulse", n, 1);
    chk("idle_wait", ioctl_wait, 0);
    ioctl_download = 1'b1;
    tick(2);
    chk("t6_clear", {overflow, dropped_cnt}, 0);
    core_busy = 1'b1;
    for (int i = 0; i < 5; i++) wr_byte(0, 25'h300 + 25'(i), 8'h70 + 8'(i));
    ioctl_download = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    core_busy = 1'b0;
    tick(10);
    chk("t6_no_we", wlog.size(), 23);
    chk("t6_wait", ioctl_wait, 0);
    wr_byte(1, 25'd0, 8'h01);
    tick();
    chk("t6_pcb", pcb, 8'h01);
    wr_byte(2, 25'd0, 8'hFF);
    tick();
    chk("t6_pcb_idx2", pcb, 8'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
